// File: rtl/cpu_pkg.sv
// Shared CPU pipeline types: load-size encodings and writeback control bundle.
package cpu_pkg;

    localparam logic [1:0] LS_BYTE = 2'd0;
    localparam logic [1:0] LS_HALF = 2'd1;
    localparam logic [1:0] LS_WORD = 2'd2;

    // Register index width carried in the control bundle; the RW parameter of
    // the pipeline registers must equal this.
    localparam int unsigned REG_IDX_W = 5;

    // Writeback controls carried from EX/MEM through to WB.
    typedef struct packed {
        logic                 rw;
        logic                 m2r;
        logic [1:0]           size;
        logic                 uns;
        logic [REG_IDX_W-1:0] waddr;
    } wb_ctrl_t;

endpackage

// File: rtl/load_align.sv
// Load return alignment: selects the addressed byte/half/word from a
// little-endian RAM word, extends it to DW bits, and flags bad alignment.
module load_align
    import cpu_pkg::*;
#(
    parameter int unsigned DW = 32
) (
    input  logic [DW-1:0] raw,
    input  logic [1:0]    off,
    input  logic [1:0]    size,
    input  logic          uns,
    output logic [DW-1:0] data,
    output logic          misalign
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    // Lane selection from the byte offset.
    always_comb begin
        byte_sel = raw[7:0];
        case (off)
            2'd0:    byte_sel = raw[7:0];
            2'd1:    byte_sel = raw[15:8];
            2'd2:    byte_sel = raw[23:16];
            default: byte_sel = raw[31:24];
        endcase
        half_sel = off[1] ? raw[31:16] : raw[15:0];
    end

    // Extension and alignment check; reserved size behaves as a word.
    always_comb begin
        data     = raw;
        misalign = 1'b0;
        case (size)
            LS_BYTE: begin
                data = {{(DW-8){~uns & byte_sel[7]}}, byte_sel};
            end
            LS_HALF: begin
                data     = {{(DW-16){~uns & half_sel[15]}}, half_sel};
                misalign = off[0];
            end
            default: begin
                data     = raw;
                misalign = (off != 2'd0);
            end
        endcase
    end

endmodule

// File: rtl/mem_wb.sv
// MEM/WB pipeline register with load return. RAM read data arrives the cycle
// the load sits in WB; it is captured on the first stalled edge so the
// writeback value stays stable for the rest of the stall.
module mem_wb
    import cpu_pkg::*;
#(
    parameter int unsigned DW = 32,
    parameter int unsigned RW = 5
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          stall,
    input  logic          flush,
    input  logic          m_valid,
    input  logic          m_reg_write,
    input  logic          m_mem_to_reg,
    input  logic [1:0]    m_load_size,
    input  logic          m_load_unsigned,
    input  logic [RW-1:0] m_waddr,
    input  logic [DW-1:0] m_alu_result,
    input  logic [DW-1:0] ram_rdata,
    output logic          wb_valid,
    output logic          wb_reg_write,
    output logic [RW-1:0] wb_waddr,
    output logic [DW-1:0] wb_wdata,
    output logic          wb_misalign
);

    wb_ctrl_t      m_ctrl;
    wb_ctrl_t      ctrl_q;
    logic          v_q;
    logic [DW-1:0] alu_q;
    logic          hold_valid_q;
    logic [DW-1:0] hold_data_q;

    logic [DW-1:0] raw;
    logic [DW-1:0] ld_data;
    logic          ld_misalign;

    // Pack incoming MEM-stage controls.
    always_comb begin
        m_ctrl       = '0;
        m_ctrl.rw    = m_reg_write;
        m_ctrl.m2r   = m_mem_to_reg;
        m_ctrl.size  = m_load_size;
        m_ctrl.uns   = m_load_unsigned;
        m_ctrl.waddr = REG_IDX_W'(m_waddr);
    end

    // Pipeline register: reset, then flush over stall over advance.
    always_ff @(posedge clk) begin
        if (rst) begin
            v_q          <= 1'b0;
            ctrl_q       <= '0;
            alu_q        <= '0;
            hold_valid_q <= 1'b0;
            hold_data_q  <= '0;
        end else if (flush) begin
            v_q          <= 1'b0;
            hold_valid_q <= 1'b0;
        end else if (stall) begin
            // Only the first stalled edge captures; later ones keep it.
            if (v_q && ctrl_q.m2r && !hold_valid_q) begin
                hold_data_q  <= ram_rdata;
                hold_valid_q <= 1'b1;
            end
        end else begin
            v_q          <= m_valid;
            ctrl_q       <= m_ctrl;
            alu_q        <= m_alu_result;
            hold_valid_q <= 1'b0;
        end
    end

    // Choose between live RAM data and the value captured during a stall.
    always_comb begin
        raw = hold_valid_q ? hold_data_q : ram_rdata;
    end

    load_align #(
        .DW(DW)
    ) u_load_align (
        .raw     (raw),
        .off     (alu_q[1:0]),
        .size    (ctrl_q.size),
        .uns     (ctrl_q.uns),
        .data    (ld_data),
        .misalign(ld_misalign)
    );

    // Writeback outputs; register 0 and misaligned loads never write.
    always_comb begin
        wb_valid     = v_q;
        wb_misalign  = v_q & ctrl_q.m2r & ld_misalign;
        wb_reg_write = v_q & ctrl_q.rw & ~wb_misalign & (ctrl_q.waddr != '0);
        wb_waddr     = RW'(ctrl_q.waddr);
        wb_wdata     = ctrl_q.m2r ? ld_data : alu_q;
    end

endmodule
